// File: rtl/stage_round_sched.sv
// Round scheduler for the 128-bit encryption stage pipeline: injects blocks,
// recirculates them ROUNDS times through a fixed-latency stage, emits results.
module stage_round_sched #(
  parameter int PIPE_LAT = 17,
  parameter int ROUNDS   = 10,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       stg_num_o,
  output logic [127:0]     stg_data_o,
  input  logic [127:0]     stg_data_i,
  output logic [4:0]       in_flight,
  output logic             busy
);

  typedef struct packed {
    logic             v;
    logic [3:0]       round;
    logic [TAG_W-1:0] tag;
  } slot_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  slot_t slots [PIPE_LAT];
  slot_t ret;
  slot_t issue;
  logic  recirc;
  logic  retire;
  logic  accept;

  // The stage has no valid of its own, so the slot leaving the tracker tells
  // us what stg_data_i holds this cycle. Gating with rst keeps the reset-cycle
  // outputs idle even while stale slots are still being cleared.
  always_comb begin
    ret        = slots[PIPE_LAT-1];
    recirc     = ~rst & ret.v & (ret.round != LAST_ROUND);
    retire     = ~rst & ret.v & (ret.round == LAST_ROUND);
    in_ready   = ~recirc;
    accept     = ~rst & in_valid & in_ready;
    stg_data_o = in_data;
    stg_num_o  = 4'd0;
    issue.v     = in_valid;
    issue.round = 4'd0;
    issue.tag   = in_tag;
    if (recirc) begin
      stg_data_o  = stg_data_i;
      stg_num_o   = ret.round + 4'd1;
      issue.v     = 1'b1;
      issue.round = ret.round + 4'd1;
      issue.tag   = ret.tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) slots[i] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      in_flight <= 5'd0;
    end else begin
      slots[0] <= issue;
      for (int i = 1; i < PIPE_LAT; i++) slots[i] <= slots[i-1];
      out_valid <= retire;
      if (retire) begin
        out_data <= stg_data_i;
        out_tag  <= ret.tag;
      end
      case ({accept, retire})
        2'b10:   in_flight <= in_flight + 5'd1;
        2'b01:   in_flight <= in_flight - 5'd1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign busy = (in_flight != 5'd0) | out_valid;

endmodule

// File: tb/tb_stage_round_sched.sv
// Bench for stage_round_sched: XOR stub stage, scoreboard of expected results,
// plus a second small instance (ROUNDS=1, PIPE_LAT=3).
module tb_stage_round_sched;

  localparam int PIPE_LAT = 17;
  localparam int ROUNDS   = 10;
  localparam int TAG_W    = 4;
  localparam int LAT      = ROUNDS * PIPE_LAT + 1;
  localparam int PL2      = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [127:0]     in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       stg_num_o;
  logic [127:0]     stg_data_o;
  logic [127:0]     stg_data_i;
  logic [4:0]       in_flight;
  logic             busy;

  logic             in_valid2 = 1'b0;
  logic             in_ready2;
  logic [127:0]     in_data2 = '0;
  logic [TAG_W-1:0] in_tag2 = '0;
  logic             out_valid2;
  logic [127:0]     out_data2;
  logic [TAG_W-1:0] out_tag2;
  logic [3:0]       stg_num2;
  logic [127:0]     stg_data_o2;
  logic [127:0]     stg_data_i2;
  logic [4:0]       in_flight2;
  logic             busy2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0]     data;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;
  exp_t sb[$];

  stage_round_sched #(.PIPE_LAT(PIPE_LAT), .ROUNDS(ROUNDS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
    .out_data(out_data), .out_tag(out_tag), .stg_num_o(stg_num_o),
    .stg_data_o(stg_data_o), .stg_data_i(stg_data_i),
    .in_flight(in_flight), .busy(busy)
  );

  stage_round_sched #(.PIPE_LAT(PL2), .ROUNDS(1), .TAG_W(TAG_W)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_tag(in_tag2), .out_valid(out_valid2),
    .out_data(out_data2), .out_tag(out_tag2), .stg_num_o(stg_num2),
    .stg_data_o(stg_data_o2), .stg_data_i(stg_data_i2),
    .in_flight(in_flight2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub stage: XOR every byte with the stage number, PIPE_LAT cycles later.
  logic [127:0] pipe1 [PIPE_LAT];
  logic [127:0] pipe2 [PL2];
  always @(posedge clk) begin
    pipe1[0] <= stg_data_o ^ {16{4'h0, stg_num_o}};
    for (int i = 1; i < PIPE_LAT; i++) pipe1[i] <= pipe1[i-1];
    pipe2[0] <= stg_data_o2 ^ {16{4'h0, stg_num2}};
    for (int i = 1; i < PL2; i++) pipe2[i] <= pipe2[i-1];
  end
  assign stg_data_i  = pipe1[PIPE_LAT-1];
  assign stg_data_i2 = pipe2[PL2-1];

  function automatic logic [7:0] roundXor(int n);
    logic [7:0] x = 8'h00;
    for (int r = 0; r < n; r++) x = x ^ 8'(r);
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v,
                               input logic [127:0] d, input logic [TAG_W-1:0] t);
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    in_data  = d;
    in_tag   = t;
  endtask

  // Scoreboard: push on accept, pop and compare on every out_valid pulse.
  int ov_cnt = 0;
  always @(negedge clk) begin
    if (out_valid) begin
      ov_cnt++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_valid", 128'(out_valid), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_tag", 128'(out_tag), 128'(e.tag));
        checkOutput("out_cycle", 128'(cyc), 128'(e.due));
      end
    end
    if (rst) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      exp_t e;
      e.data = in_data ^ {16{roundXor(ROUNDS)}};
      e.tag  = in_tag;
      e.due  = cyc + LAT;
      sb.push_back(e);
    end
  end

  logic [127:0]     fill_data [20];
  logic [TAG_W-1:0] fill_tag  [20];

  initial begin
    int idx;
    int k;
    logic [127:0] d2;

    // Reset state and reset-time outputs.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, {4{$urandom}}, 4'hA);
      @(negedge clk);
      checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
      checkOutput("rst_stg_num", 128'(stg_num_o), 128'(0));
      checkOutput("rst_stg_data", stg_data_o, in_data);
    end
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_out_data", out_data, 128'(0));
    checkOutput("rst_out_tag", 128'(out_tag), 128'(0));
    checkOutput("rst_in_flight", 128'(in_flight), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));

    // Idle.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, 1'b0, 128'(i), 4'h0);
      @(negedge clk);
      checkOutput("idle_out_valid", 128'(out_valid), 128'(0));
      checkOutput("idle_in_flight", 128'(in_flight), 128'(0));
      checkOutput("idle_busy", 128'(busy), 128'(0));
      checkOutput("idle_stg_num", 128'(stg_num_o), 128'(0));
    end

    // Single block, data 0, tag 3.
    for (k = 0; k <= 175; k++) begin
      applyStimulus(1'b0, k == 0, 128'(0), 4'd3);
      @(negedge clk);
      if (k == 0) checkOutput("single_ready", 128'(in_ready), 128'(1));
      if (k % PIPE_LAT == 0 && k < ROUNDS * PIPE_LAT)
        checkOutput("single_stg_num", 128'(stg_num_o), 128'(k / PIPE_LAT));
      checkOutput("single_in_flight", 128'(in_flight),
                  128'((k >= 1 && k <= LAT - 1) ? 1 : 0));
      if (k == LAT) checkOutput("single_out_data", out_data, {16{8'h01}});
    end

    // Back-to-back fill with in_valid held high.
    for (int i = 0; i < 20; i++) begin
      fill_data[i] = {$urandom, $urandom, $urandom, 32'(i)};
      fill_tag[i]  = 4'(i);
    end
    idx = 0;
    k = 0;
    while (idx < 20 && k < 400) begin
      applyStimulus(1'b0, 1'b1, fill_data[idx], fill_tag[idx]);
      @(negedge clk);
      if (k == PIPE_LAT) begin
        checkOutput("fill_in_flight", 128'(in_flight), 128'(PIPE_LAT));
        checkOutput("fill_ready_low", 128'(in_ready), 128'(0));
      end
      if (k == 5 * PIPE_LAT) begin
        checkOutput("prio_ready", 128'(in_ready), 128'(0));
        checkOutput("prio_stg_num", 128'(stg_num_o), 128'(5));
        checkOutput("prio_stg_data", stg_data_o, stg_data_i);
      end
      if (in_ready) begin
        checkOutput("accept_cycle", 128'(k),
                    128'(idx < PIPE_LAT ? idx : (LAT - 1) + idx - PIPE_LAT));
        idx++;
      end
      k++;
    end
    checkOutput("fill_all_accepted", 128'(idx), 128'(20));
    k = 0;
    while (sb.size() != 0 && k < 1000) begin
      applyStimulus(1'b0, 1'b0, '0, '0);
      k++;
    end
    checkOutput("fill_drain", 128'(sb.size()), 128'(0));
    @(negedge clk);
    checkOutput("fill_end_in_flight", 128'(in_flight), 128'(0));
    checkOutput("fill_end_busy", 128'(busy), 128'(0));

    // Reset mid-run with 10 blocks in flight.
    for (k = 0; k <= 400; k++) begin
      applyStimulus(k == 90, (k < 10) || (k == 91), {$urandom, $urandom, $urandom, $urandom},
                    4'(k));
      @(negedge clk);
      if (k == 89) checkOutput("mid_in_flight_pre", 128'(in_flight), 128'(10));
      if (k == 91) begin
        ov_cnt = 0;
        checkOutput("mid_in_flight_post", 128'(in_flight), 128'(0));
        checkOutput("mid_busy_post", 128'(busy), 128'(0));
        checkOutput("mid_ready_post", 128'(in_ready), 128'(1));
      end
    end
    checkOutput("mid_out_count", 128'(ov_cnt), 128'(1));
    checkOutput("mid_sb_empty", 128'(sb.size()), 128'(0));

    // Second instance: ROUNDS=1, PIPE_LAT=3.
    d2 = {$urandom, $urandom, $urandom, $urandom};
    for (k = 0; k <= 8; k++) begin
      @(posedge clk);
      #1;
      in_valid2 = (k == 0);
      in_data2  = d2;
      in_tag2   = 4'd5;
      @(negedge clk);
      if (k == 0) checkOutput("sweep_ready", 128'(in_ready2), 128'(1));
      checkOutput("sweep_stg_num", 128'(stg_num2), 128'(0));
      checkOutput("sweep_out_valid", 128'(out_valid2), 128'(k == PL2 + 1 ? 1 : 0));
      if (k == PL2 + 1) begin
        checkOutput("sweep_out_data", out_data2, d2);
        checkOutput("sweep_out_tag", 128'(out_tag2), 128'(5));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
